// File: rtl/h80cpu_io.sv
// h80cpu_io: I/O bus slave for the h80 CPU with one 8N1 UART transmitter and a status register.
// Latency: 1 clock from a pending request to the done toggle, with rd_data loaded on the same edge.
// Backpressure: a TXDATA write stalls while the transmitter is busy. Every other request completes at once.
//
// Ports:
//   clk, reset_         single clock; asynchronous active-low reset
//   addr, cmd, wr_data  request fields; held stable while run != done
//   run / done          toggle handshake; a request is pending while they differ
//   rd_data             registered read data; holds its value between reads
//   uart_txp            registered UART TX line; idle high
module h80cpu_io #(
  parameter int CLK_FREQ = 27000000,
  parameter int BAUD     = 115200
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic [15:0] addr,
  input  logic [2:0]  cmd,
  input  logic        run,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        done,
  output logic        uart_txp
);

  // Clocks per UART bit. The design needs this to be at least 2.
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

  localparam logic [2:0] CMD_READ_W  = 3'd0;
  localparam logic [2:0] CMD_WRITE_W = 3'd1;
  localparam logic [2:0] CMD_READ_B  = 3'd2;
  localparam logic [2:0] CMD_WRITE_B = 3'd3;

  localparam logic [15:0] ADDR_TXDATA = 16'h0000;
  localparam logic [15:0] ADDR_STATUS = 16'h0001;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  tx_state_t      tx_state;
  logic [CW-1:0]  baud_cnt;
  logic [2:0]     bit_cnt;
  logic [7:0]     tx_shift;

  logic           pending;
  logic           tx_busy;
  logic           is_read;
  logic           is_write;
  logic           txdata_wr;
  logic           accept;
  logic [15:0]    rd_val;

  // Only the low byte of write data reaches the transmitter.
  logic [7:0]     unused_wr_hi;
  assign unused_wr_hi = wr_data[15:8];

  always_comb begin
    pending   = run ^ done;
    tx_busy   = (tx_state != TX_IDLE);
    is_read   = (cmd == CMD_READ_W)  || (cmd == CMD_READ_B);
    is_write  = (cmd == CMD_WRITE_W) || (cmd == CMD_WRITE_B);
    txdata_wr = is_write && (addr == ADDR_TXDATA);
    // A TXDATA write waits for an idle transmitter, so bytes are never dropped.
    accept    = pending && !(txdata_wr && tx_busy);

    rd_val = 16'h0000;
    if (addr == ADDR_STATUS) begin
      rd_val = {15'b0, tx_busy};
    end
    if (cmd == CMD_READ_B) begin
      rd_val[15:8] = 8'h00;
    end
  end

  // Bus side. Reserved commands and writes complete without touching rd_data.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      done    <= 1'b0;
      rd_data <= 16'h0000;
    end else if (accept) begin
      done <= ~done;
      if (is_read) begin
        rd_data <= rd_val;
      end
    end
  end

  // UART transmitter. The line is registered, so it falls on the edge that accepts the write.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      tx_state <= TX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
      tx_shift <= 8'h00;
      uart_txp <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (accept && txdata_wr) begin
            tx_state <= TX_START;
            tx_shift <= wr_data[7:0];
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            uart_txp <= 1'b0;
          end
        end
        TX_START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            tx_state <= TX_DATA;
            uart_txp <= tx_shift[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx_state <= TX_STOP;
              uart_txp <= 1'b1;
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              uart_txp <= tx_shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          // Back in IDLE after this edge. A stalled write is accepted on the next edge,
          // which leaves exactly one idle-high clock between frames.
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            tx_state <= TX_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          tx_state <= TX_IDLE;
          uart_txp <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_h80cpu_io.sv
// tb_h80cpu_io: testbench for h80cpu_io with CLK_FREQ=1600 and BAUD=100, so DIV=16.
// The reference keeps a list of frames (accept edge, byte) and derives the expected line level arithmetically.
// Request completion edges, read data and the TX line are compared against that reference.
module tb_h80cpu_io;

  localparam int DIV   = 16;
  localparam int FRAME = 10 * DIV;

  logic        clk;
  logic        reset_;
  logic [15:0] addr;
  logic [2:0]  cmd;
  logic        run;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        done;
  logic        uart_txp;

  h80cpu_io #(.CLK_FREQ(1600), .BAUD(100)) dut (
    .clk      (clk),
    .reset_   (reset_),
    .addr     (addr),
    .cmd      (cmd),
    .run      (run),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .done     (done),
    .uart_txp (uart_txp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc holds the index of the most recent rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: each frame occupies FRAME clocks starting at its accept edge.
  typedef struct {
    int         a;
    logic [7:0] d;
  } frame_t;

  frame_t      fq[$];
  int          next_free = 0;
  logic [15:0] exp_rd    = 16'h0000;

  function automatic logic exp_txp(input int e);
    foreach (fq[i]) begin
      if (e >= fq[i].a && e < fq[i].a + FRAME) begin
        int k;
        k = (e - fq[i].a) / DIV;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return fq[i].d[k-1];
      end
    end
    return 1'b1;
  endfunction

  // Busy as seen by the DUT at edge e, which is the state left behind by edge e-1.
  function automatic logic model_busy(input int e);
    foreach (fq[i]) begin
      if (e - 1 >= fq[i].a && e - 1 < fq[i].a + FRAME) return 1'b1;
    end
    return 1'b0;
  endfunction

  // The line is compared on every falling edge.
  always @(negedge clk) begin
    check("txp", {15'b0, uart_txp}, {15'b0, exp_txp(cyc)});
  end

  task automatic wait_done(input int exp_e, input string tag);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (done == run) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({tag, "_timeout"}, 16'd0, 16'd1);
    else     check({tag, "_edge"}, cyc[15:0], exp_e[15:0]);
  endtask

  task automatic do_req(input logic [2:0] c, input logic [15:0] a, input logic [15:0] w, input string tag);
    int   e;
    int   acc;
    logic is_tx;
    @(negedge clk);
    e     = cyc + 1;
    is_tx = (c == 3'd1 || c == 3'd3) && (a == 16'h0000);
    acc   = e;
    if (is_tx) begin
      if (next_free > acc) acc = next_free;
      fq.push_back('{a: acc, d: w[7:0]});
      next_free = acc + FRAME + 1;
    end
    if (c == 3'd0 || c == 3'd2) begin
      exp_rd = (a == 16'h0001) ? {15'b0, model_busy(acc)} : 16'h0000;
      if (c == 3'd2) exp_rd = exp_rd & 16'h00FF;
    end
    addr    = a;
    cmd     = c;
    wr_data = w;
    run     = ~run;
    wait_done(acc, tag);
    check({tag, "_rd"}, rd_data, exp_rd);
  endtask

  task automatic idle_wait();
    while (cyc < next_free) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [2:0]  rc;
    logic [15:0] ra;
    logic [15:0] rw;

    // Reset held with a request already pending.
    reset_  = 1'b0;
    run     = 1'b1;
    addr    = 16'h1234;
    cmd     = 3'd0;
    wr_data = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_done", {15'b0, done}, 16'd0);
    check("rst_rd", rd_data, 16'h0000);
    check("rst_txp", {15'b0, uart_txp}, 16'd1);
    c0     = cyc;
    reset_ = 1'b1;
    wait_done(c0 + 1, "rst_req");
    check("rst_req_rd", rd_data, 16'h0000);

    // Byte write 0x48. The monitor follows the whole frame.
    do_req(3'd3, 16'h0000, 16'h0048, "wr48");
    // Status word and byte reads during the frame, then a word read after the stop bit.
    do_req(3'd0, 16'h0001, 16'h0000, "st_busy");
    do_req(3'd2, 16'h0001, 16'h0000, "stb_busy");
    idle_wait();
    do_req(3'd0, 16'h0001, 16'h0000, "st_idle");
    // Word write: only the low byte is sent.
    do_req(3'd1, 16'h0000, 16'hAB65, "wrw65");
    idle_wait();

    // A second write issued back to back stalls until the first frame ends.
    do_req(3'd3, 16'h0000, 16'h0041, "wr41");
    do_req(3'd3, 16'h0000, 16'h0042, "wr42_stall");
    idle_wait();

    // Reserved commands and unmapped addresses.
    do_req(3'd3, 16'h0000, 16'h0055, "wr55");
    do_req(3'd0, 16'h0001, 16'h0000, "st_busy2");
    do_req(3'd6, 16'h0001, 16'h0000, "rsv_hold");
    idle_wait();
    do_req(3'd6, 16'h0000, 16'h00FF, "rsv_notx");
    do_req(3'd0, 16'h1234, 16'h0000, "unmapped");
    do_req(3'd1, 16'h0001, 16'h00AA, "st_wr_ign");

    // Reset during data bit 3. The byte 0xF0 has bit 3 low, so the line is low at the reset point.
    do_req(3'd3, 16'h0000, 16'h00F0, "wrF0");
    c0 = fq[fq.size()-1].a;
    while (cyc < c0 + 4 * DIV + 6) @(posedge clk);
    #2;
    fq.delete();
    next_free = 0;
    exp_rd    = 16'h0000;
    reset_    = 1'b0;
    #1;
    check("midrst_txp", {15'b0, uart_txp}, 16'd1);
    check("midrst_done", {15'b0, done}, 16'd0);
    check("midrst_rd", rd_data, 16'h0000);
    run = 1'b0;
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
    do_req(3'd3, 16'h0000, 16'h003C, "wr3C_after_rst");
    idle_wait();

    // Random traffic against the reference.
    for (int i = 0; i < 40; i++) begin
      rc = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       ra = 16'h0000;
        1:       ra = 16'h0001;
        2:       ra = 16'h0000;
        default: ra = 16'($urandom);
      endcase
      rw = 16'($urandom);
      do_req(rc, ra, rw, "rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    idle_wait();
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
